cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/riscv_pkg.sv | 17 +
 rtl/cdb_arbiter.sv | 146 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types.
//   XLEN                  - architectural data width
//   ReorderBufferTagWidth - width of a reorder-buffer entry tag
//   fu_complete_t         - result a functional unit hands to the common data bus
package riscv_pkg;

  localparam int XLEN                  = 32;
  localparam int ReorderBufferTagWidth = 5;

  typedef struct packed {
    logic                             valid;
    logic [ReorderBufferTagWidth-1:0] tag;
    logic [XLEN-1:0]                  value;
    logic                             exception;
  } fu_complete_t;

endpackage

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter.
// Chooses one functional-unit result per cycle and broadcasts it on the CDB.
// Selection is round-robin. A unit whose request has been refused for
// StarveLimit consecutive cycles is "starved", and starved units take
// priority, lowest index first. A full flush suppresses all grants. A
// partial flush hides requests that are younger than the flush tag.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_fu_complete    per-FU result requests (element valid = request)
//   o_grant          one-hot-or-zero grant, combinational in the request cycle
//   o_cdb            registered broadcast of the granted result
//   o_cdb_fu_id      index of the FU that produced o_cdb
//   i_flush          full flush
//   i_flush_en       partial flush enable, boundary given by i_flush_tag
//   i_rob_head_tag   ROB head, reference point for tag age comparison
module cdb_arbiter #(
  parameter int NumFus      = 4,
  parameter int StarveLimit = 8
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst_n,
  input  riscv_pkg::fu_complete_t                       i_fu_complete [NumFus],
  output logic [NumFus-1:0]                             o_grant,
  output riscv_pkg::fu_complete_t                       o_cdb,
  output logic [$clog2(NumFus)-1:0]                     o_cdb_fu_id,
  input  logic                                          i_flush,
  input  logic                                          i_flush_en,
  input  logic [riscv_pkg::ReorderBufferTagWidth-1:0]   i_flush_tag,
  input  logic [riscv_pkg::ReorderBufferTagWidth-1:0]   i_rob_head_tag
);

  localparam int IdxW = $clog2(NumFus);
  localparam int SumW = IdxW + 1;
  localparam int TagW = riscv_pkg::ReorderBufferTagWidth;
  localparam int CntW = 4;

  // Distance of a tag from the ROB head. Wraparound subtraction turns
  // circular ROB order into plain unsigned order.
  function automatic logic [TagW-1:0] age_of(input logic [TagW-1:0] tag,
                                             input logic [TagW-1:0] head);
    return tag - head;
  endfunction

  // Saturating increment for the wait counters.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] cnt);
    return (cnt == {CntW{1'b1}}) ? cnt : cnt + CntW'(1);
  endfunction

  // Increment modulo NumFus. Used to move the round-robin pointer.
  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
    return (idx == IdxW'(NumFus - 1)) ? '0 : idx + IdxW'(1);
  endfunction

  logic [IdxW-1:0]   rr_ptr;
  logic [CntW-1:0]   wait_cnt [NumFus];
  logic [NumFus-1:0] vld_p0;
  logic [NumFus-1:0] starved_p0;
  logic [TagW-1:0]   flush_age;
  logic [IdxW-1:0]   win_idx;
  logic              grant_vld;

  riscv_pkg::fu_complete_t cdb_p1;
  logic [IdxW-1:0]         cdb_fu_id_p1;

  // ---- Stage p0: eligibility. A request is eligible when it is valid and
  // not younger than an active partial-flush boundary. Masked requests are
  // treated as absent, so they also do not accumulate wait time.
  always_comb begin
    flush_age = age_of(i_flush_tag, i_rob_head_tag);
    for (int i = 0; i < NumFus; i++) begin
      vld_p0[i] = i_fu_complete[i].valid &&
                  !(i_flush_en &&
                    (age_of(i_fu_complete[i].tag, i_rob_head_tag) > flush_age));
      starved_p0[i] = vld_p0[i] && (wait_cnt[i] >= CntW'(StarveLimit));
    end
  end

  // ---- Stage p0: winner selection. Starvation overrides round-robin.
  always_comb begin
    logic             found;
    logic [SumW-1:0]  sum;
    logic [IdxW-1:0]  cand;
    win_idx = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    if (|starved_p0) begin
      // Descending scan, so the lowest starved index is the one left in win_idx.
      for (int i = NumFus - 1; i >= 0; i--) begin
        if (starved_p0[i]) win_idx = IdxW'(i);
      end
    end else begin
      for (int off = 0; off < NumFus; off++) begin
        sum = {1'b0, rr_ptr} + SumW'(off);
        if (sum >= SumW'(NumFus)) sum = sum - SumW'(NumFus);
        cand = sum[IdxW-1:0];
        if (!found && vld_p0[cand]) begin
          found   = 1'b1;
          win_idx = cand;
        end
      end
    end
  end

  // Gating with i_rst_n keeps o_grant at zero for the whole reset period,
  // even though the rest of the grant path is purely combinational.
  assign grant_vld = (|vld_p0) && !i_flush && i_rst_n;
  assign o_grant   = grant_vld ? (NumFus'(1) << win_idx) : '0;

  // ---- Stage p0 -> p1: arbitration state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr <= '0;
      for (int i = 0; i < NumFus; i++) wait_cnt[i] <= '0;
    end else begin
      if (grant_vld) rr_ptr <= wrap_inc(win_idx);
      for (int i = 0; i < NumFus; i++) begin
        if (i_flush || !vld_p0[i] || o_grant[i]) wait_cnt[i] <= '0;
        else                                      wait_cnt[i] <= sat_inc(wait_cnt[i]);
      end
    end
  end

  // ---- Stage p0 -> p1: CDB broadcast register.
  // An entry is held for exactly one cycle. When there is no grant, the
  // valid bit drops. This same path covers two flush cases. A full flush
  // always blocks the grant. A partial flush can only capture a winner that
  // is not masked, so a registered entry younger than the flush boundary
  // never survives into the next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cdb_p1       <= '0;
      cdb_fu_id_p1 <= '0;
    end else if (grant_vld) begin
      cdb_p1       <= i_fu_complete[win_idx];
      cdb_fu_id_p1 <= win_idx;
    end else begin
      cdb_p1.valid <= 1'b0;
    end
  end

  assign o_cdb       = cdb_p1;
  assign o_cdb_fu_id = cdb_fu_id_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter. Two instances share the same stimulus: one uses the
// default starvation limit and the other uses a limit of 2. A reference model
// that tracks each instance's state is compared against both on every
// falling edge. Directed scenarios also pin literal expected values.
module tb_cdb_arbiter;
  import riscv_pkg::*;

  localparam int N  = 4;
  localparam int TW = ReorderBufferTagWidth;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  fu_complete_t    fu [N];
  logic            flush, flush_en;
  logic [TW-1:0]   flush_tag, head;

  logic [N-1:0]    g0, g1;
  fu_complete_t    cdb0, cdb1;
  logic [1:0]      id0, id1;

  cdb_arbiter #(.NumFus(N), .StarveLimit(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_fu_complete(fu), .o_grant(g0),
    .o_cdb(cdb0), .o_cdb_fu_id(id0), .i_flush(flush), .i_flush_en(flush_en),
    .i_flush_tag(flush_tag), .i_rob_head_tag(head));

  cdb_arbiter #(.NumFus(N), .StarveLimit(2)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_fu_complete(fu), .o_grant(g1),
    .o_cdb(cdb1), .o_cdb_fu_id(id1), .i_flush(flush), .i_flush_en(flush_en),
    .i_flush_tag(flush_tag), .i_rob_head_tag(head));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int     lim [2] = '{8, 2};
  int     m_rr   [2];
  int     m_wait [2][N];
  logic   m_cv   [2];
  int     m_ctag [2];
  longint m_cval [2];
  int     m_cexc [2];
  int     m_id   [2];

  function automatic int age(input int x);
    return (x - int'(head)) & ((1 << TW) - 1);
  endfunction

  function automatic bit elig(input int i);
    return fu[i].valid && !(flush_en && (age(int'(fu[i].tag)) > age(int'(flush_tag))));
  endfunction

  function automatic int exp_winner(input int k);
    if (!rst_n || flush) return -1;
    for (int i = 0; i < N; i++)
      if (elig(i) && m_wait[k][i] >= lim[k]) return i;
    for (int off = 0; off < N; off++)
      if (elig((m_rr[k] + off) % N)) return (m_rr[k] + off) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    fu_complete_t c;
    logic [N-1:0] gact;
    int           aid, w, eg;
    for (int k = 0; k < 2; k++) begin
      c    = (k == 0) ? cdb0 : cdb1;
      gact = (k == 0) ? g0 : g1;
      aid  = (k == 0) ? int'(id0) : int'(id1);
      if (!rst_n) begin
        m_rr[k] = 0; m_cv[k] = 1'b0; m_ctag[k] = 0; m_cval[k] = 0;
        m_cexc[k] = 0; m_id[k] = 0;
        for (int i = 0; i < N; i++) m_wait[k][i] = 0;
      end
      chk($sformatf("model_cdb_valid[%0d]", k), c.valid, m_cv[k]);
      if (m_cv[k]) begin
        chk($sformatf("model_cdb_tag[%0d]", k), c.tag, m_ctag[k]);
        chk($sformatf("model_cdb_value[%0d]", k), c.value, m_cval[k]);
        chk($sformatf("model_cdb_exc[%0d]", k), c.exception, m_cexc[k]);
      end
      chk($sformatf("model_cdb_fu_id[%0d]", k), aid, m_id[k]);
      w  = exp_winner(k);
      eg = (w < 0) ? 0 : (1 << w);
      chk($sformatf("model_grant[%0d]", k), gact, eg);
      if (rst_n) begin
        for (int i = 0; i < N; i++) begin
          if (flush || !elig(i) || i == w) m_wait[k][i] = 0;
          else if (m_wait[k][i] < 15)      m_wait[k][i] = m_wait[k][i] + 1;
        end
        if (w >= 0) begin
          m_cv[k]   = 1'b1;
          m_ctag[k] = int'(fu[w].tag);
          m_cval[k] = longint'(fu[w].value);
          m_cexc[k] = int'(fu[w].exception);
          m_id[k]   = w;
          m_rr[k]   = (w + 1) % N;
        end else begin
          m_cv[k] = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    for (int i = 0; i < N; i++) fu[i] = '0;
    flush = 1'b0; flush_en = 1'b0; flush_tag = '0; head = '0;
  endtask

  task automatic set_fu(input int i, input int tag, input int val);
    fu[i].valid     = 1'b1;
    fu[i].tag       = TW'(tag);
    fu[i].value     = 32'(val);
    fu[i].exception = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] exp_g [5];
  int           exp_t [5];

  initial begin
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_t = '{1, 2, 3, 4, 1};
    rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < N; i++) set_fu(i, i + 1, 7);

    // Reset state, requests present
    @(negedge clk);
    chk("reset_grant0", g0, 0);
    chk("reset_grant1", g1, 0);
    chk("reset_cdb_valid", cdb0.valid, 0);
    chk("reset_fu_id", id0, 0);

    next_cycle(); rst_n = 1'b1; idle_inputs();
    @(negedge clk);

    // Round-robin with four continuous requesters
    next_cycle();
    for (int i = 0; i < N; i++) set_fu(i, i + 1, 100 + i);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
      if (c < 5) chk($sformatf("rr_grant_c%0d", c), g0, exp_g[c]);
      if (c >= 1) begin
        chk($sformatf("rr_cdb_valid_c%0d", c), cdb0.valid, 1);
        chk($sformatf("rr_cdb_tag_c%0d", c), cdb0.tag, exp_t[c-1]);
      end
    end
    next_cycle(); idle_inputs(); @(negedge clk);
    next_cycle(); @(negedge clk);
    chk("idle_cdb_valid", cdb0.valid, 0);

    // Single requester, back-to-back grants
    next_cycle(); set_fu(2, 5, 55);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) next_cycle();
      if (c == 3) idle_inputs();
      @(negedge clk);
      if (c < 3) chk($sformatf("solo_grant_c%0d", c), g0, 4'b0100);
      if (c >= 1 && c <= 3) begin
        chk($sformatf("solo_cdb_valid_c%0d", c), cdb0.valid, 1);
        chk($sformatf("solo_cdb_tag_c%0d", c), cdb0.tag, 5);
      end
      if (c == 4) chk("solo_cdb_drop", cdb0.valid, 0);
    end

    // Starvation override on the StarveLimit=2 instance
    next_cycle(); rst_n = 1'b0;
    next_cycle(); rst_n = 1'b1;
    set_fu(0, 10, 1); set_fu(1, 11, 2); set_fu(3, 13, 4);
    @(negedge clk);
    chk("starve_c0", g1, 4'b0001);
    next_cycle(); @(negedge clk);
    chk("starve_c1", g1, 4'b0010);
    next_cycle(); set_fu(2, 12, 3); @(negedge clk);
    chk("starve_override", g1, 4'b1000);
    chk("starve_rr_default", g0, 4'b0100);
    next_cycle(); @(negedge clk);
    chk("starve_cdb_tag", cdb1.tag, 13);
    chk("starve_cdb_id", id1, 3);

    // Partial flush masks the younger request
    next_cycle(); idle_inputs();
    flush_en = 1'b1; flush_tag = 5'd3;
    set_fu(0, 5, 50); set_fu(1, 2, 20);
    @(negedge clk);
    chk("pflush_grant0", g0, 4'b0010);
    chk("pflush_grant1", g1, 4'b0010);
    next_cycle(); idle_inputs(); @(negedge clk);
    chk("pflush_cdb_valid", cdb0.valid, 1);
    chk("pflush_cdb_tag", cdb0.tag, 2);
    chk("pflush_cdb_id", id0, 1);

    // Registered entry younger than a partial flush boundary
    next_cycle(); set_fu(0, 6, 66); @(negedge clk);
    next_cycle(); idle_inputs(); flush_en = 1'b1; flush_tag = 5'd4; @(negedge clk);
    chk("pflush_reg_before", cdb0.valid, 1);
    chk("pflush_reg_tag", cdb0.tag, 6);
    next_cycle(); idle_inputs(); @(negedge clk);
    chk("pflush_reg_after", cdb0.valid, 0);

    // Full flush with every FU requesting
    next_cycle(); for (int i = 0; i < N; i++) set_fu(i, i + 1, 9); @(negedge clk);
    next_cycle(); flush = 1'b1; @(negedge clk);
    chk("flush_grant0", g0, 0);
    chk("flush_grant1", g1, 0);
    next_cycle(); idle_inputs(); @(negedge clk);
    chk("flush_cdb_valid", cdb0.valid, 0);

    // Reset mid-stream
    next_cycle(); for (int i = 0; i < N; i++) set_fu(i, i + 1, 8); @(negedge clk);
    next_cycle(); @(negedge clk);
    chk("midrst_cdb_before", cdb0.valid, 1);
    next_cycle(); rst_n = 1'b0; #1;
    chk("midrst_cdb_valid", cdb0.valid, 0);
    chk("midrst_grant0", g0, 0);
    chk("midrst_grant1", g1, 0);
    @(negedge clk);
    next_cycle(); rst_n = 1'b1; idle_inputs(); set_fu(1, 3, 1); set_fu(3, 4, 2);
    @(negedge clk);
    chk("postrst_first_grant", g0, 4'b0010);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      next_cycle();
      for (int i = 0; i < N; i++) begin
        fu[i].valid     = ($urandom % 4) != 0;
        fu[i].tag       = TW'($urandom);
        fu[i].value     = $urandom;
        fu[i].exception = $urandom % 2;
      end
      head      = TW'($urandom);
      flush_tag = TW'($urandom);
      flush_en  = ($urandom % 5) == 0;
      flush     = ($urandom % 25) == 0;
      rst_n     = ($urandom % 200) != 0;
    end
    next_cycle(); rst_n = 1'b1; idle_inputs();
    repeat (3) next_cycle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
